// File: rtl/quad_input_filter.sv
// Quadrature input conditioner: two-flop synchronisers, per-channel stability
// filters, and a step/dir/illegal-transition decoder with a saturating error count.
module quad_input_filter #(
  parameter int FILT_LEN = 4,
  parameter int CNT_W    = 8,
  parameter int ERR_W    = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic             filt_en,
  input  logic             err_clr,
  output logic             A_f,
  output logic             B_f,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  state_t                 state_q, state_d;
  logic [1:0]             init_q, init_d;
  // Channel vectors are {A, B}; A is the MSB throughout.
  logic [1:0]             s1_q, s2_q;
  logic [1:0]             f_q, f_d;
  logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]             prev_q, prev_d;
  logic                   step_d, dir_d, err_d;
  logic [ERR_W-1:0]       err_cnt_d;
  logic [1:0]             pos_cur, pos_prev, delta;
  logic                   run;

  assign run      = (state_q == ST_RUN);
  // Gray position along the forward cycle 00->10->11->01 is {B, A^B}.
  assign pos_cur  = {f_q[0], f_q[1] ^ f_q[0]};
  assign pos_prev = {prev_q[0], prev_q[1] ^ prev_q[0]};
  assign delta    = pos_cur - pos_prev;

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    f_d       = f_q;
    cnt_d     = '0;
    step_d    = 1'b0;
    err_d     = 1'b0;
    dir_d     = dir;
    err_cnt_d = err_cnt;

    if (!run) begin
      init_d = init_q + 2'd1;
      if (init_q == 2'd2) state_d = ST_RUN;
    end

    for (int i = 0; i < 2; i++) begin
      if (!run || !filt_en) begin
        f_d[i] = s2_q[i];
      end else if (s2_q[i] != f_q[i]) begin
        if (cnt_q[i] == CNT_LAST) f_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    if (run) begin
      if (delta == 2'd1) begin
        step_d = 1'b1;
        dir_d  = 1'b1;
      end else if (delta == 2'd3) begin
        step_d = 1'b1;
        dir_d  = 1'b0;
      end else if (delta == 2'd2) begin
        err_d = 1'b1;
      end
    end

    if (err_clr)                      err_cnt_d = '0;
    else if (err_d && err_cnt != '1)  err_cnt_d = err_cnt + ERR_W'(1);

    // During INIT prev shadows the level being loaded, so the power-up level never decodes.
    prev_d = run ? f_q : f_d;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      step    <= 1'b0;
      dir     <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      s1_q    <= {A, B};
      s2_q    <= s1_q;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      step    <= step_d;
      dir     <= dir_d;
      err     <= err_d;
      err_cnt <= err_cnt_d;
    end
  end

  assign A_f = f_q[1];
  assign B_f = f_q[0];

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter: cycle-by-cycle comparison against a
// window-based behavioural model plus hand-computed checkpoints.
module tb_quad_input_filter;
  localparam int FILT_LEN = 4;
  localparam int CNT_W    = 8;
  localparam int ERR_W    = 8;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic             CLK, reset, A, B, filt_en, err_clr;
  logic             A_f, B_f, step, dir, err;
  logic [ERR_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int step_seen = 0, err_seen = 0, af_tog = 0;
  logic last_af = 1'b0;

  quad_input_filter #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .CLK(CLK), .reset(reset), .A(A), .B(B), .filt_en(filt_en), .err_clr(err_clr),
    .A_f(A_f), .B_f(B_f), .step(step), .dir(dir), .err(err), .err_cnt(err_cnt)
  );

  // Clock / reset: rising edges at 7, 17, 27 ... so input changes at 5 ns multiples never race them.
  initial begin
    CLK = 1'b0;
    #2;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sync pipeline, stability window of the last FILT_LEN samples,
  // and decoding by position along the quadrature cycle.
  bit m_s1a, m_s2a, m_s1b, m_s2b, m_af, m_bf, m_step, m_dir, m_err, m_run;
  bit n_af, n_bf;
  bit [1:0] m_prev, m_cur;
  bit [FILT_LEN-1:0] wa, wb, we;
  int m_init, m_ecnt, m_d;

  function automatic int gpos(input bit [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      {m_s1a, m_s2a, m_s1b, m_s2b, m_af, m_bf, m_step, m_dir, m_err} = '0;
      m_prev = '0; wa = '0; wb = '0; we = '0; m_init = 0; m_ecnt = 0;
    end else begin
      m_run = (m_init >= 3);
      m_cur = {m_af, m_bf};
      m_d   = (gpos(m_cur) - gpos(m_prev) + 4) % 4;
      wa = {wa[FILT_LEN-2:0], m_s2a};
      wb = {wb[FILT_LEN-2:0], m_s2b};
      we = {we[FILT_LEN-2:0], bit'(m_run && filt_en)};
      if (!m_run || !filt_en) begin
        n_af = m_s2a;
        n_bf = m_s2b;
      end else begin
        n_af = (we == '1 && wa == {FILT_LEN{~m_af}}) ? ~m_af : m_af;
        n_bf = (we == '1 && wb == {FILT_LEN{~m_bf}}) ? ~m_bf : m_bf;
      end
      m_step = m_run && (m_d == 1 || m_d == 3);
      m_err  = m_run && (m_d == 2);
      if (m_run && m_d == 1) m_dir = 1'b1;
      else if (m_run && m_d == 3) m_dir = 1'b0;
      if (err_clr) m_ecnt = 0;
      else if (m_err && m_ecnt < ERR_MAX) m_ecnt++;
      m_prev = m_run ? m_cur : {n_af, n_bf};
      m_af = n_af;
      m_bf = n_bf;
      m_s2a = m_s1a; m_s1a = A;
      m_s2b = m_s1b; m_s1b = B;
      if (m_init < 3) m_init++;
    end
  end

  // Scoreboard compare on the falling edge, plus event tallies for the directed checkpoints.
  always @(negedge CLK) begin
    check("A_f",     A_f,     m_af);
    check("B_f",     B_f,     m_bf);
    check("step",    step,    m_step);
    check("dir",     dir,     m_dir);
    check("err",     err,     m_err);
    check("err_cnt", err_cnt, m_ecnt);
    step_seen += step;
    err_seen  += err;
    if (A_f !== last_af) af_tog++;
    last_af = A_f;
  end

  task automatic wait_clocks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic measure_a(input string name, input int exp);
    int n;
    logic old;
    old = A_f;
    A = ~A;
    n = 0;
    while (A_f === old && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(name, n, exp);
  endtask

  task automatic quad(input bit a_first, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) #50; else #25;
      if ((i % 2 == 0) == a_first) A = ~A;
      else                         B = ~B;
    end
    wait_clocks(12);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (bench did not finish)");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int s0, e0, t0;
    reset = 1'b0; A = 1'b1; B = 1'b1; filt_en = 1'b1; err_clr = 1'b0;
    #1;
    check("rst_outputs", {A_f, B_f, step, dir, err, err_cnt}, 0);
    #30 reset = 1'b1;

    // Power-up: level appears on the third clock with no decode activity.
    wait_clocks(2);
    check("init_af_early", A_f, 0);
    wait_clocks(1);
    check("init_level", {A_f, B_f}, 2'b11);
    wait_clocks(10);
    check("init_quiet", step_seen + err_seen + err_cnt, 0);

    // Filtered latency on a single edge: s1, s2, three counts, then the update.
    s0 = step_seen;
    wait_clocks(1);
    measure_a("lat_fall", 6);
    wait_clocks(8);
    measure_a("lat_rise", 6);
    wait_clocks(8);
    check("lat_steps", step_seen - s0, 2);

    // Forward then reverse, eight edges each.
    s0 = step_seen; e0 = err_seen;
    quad(1'b1, 8);
    check("fwd_steps", step_seen - s0, 8);
    check("fwd_dir", dir, 1);
    check("fwd_err", err_seen - e0, 0);
    s0 = step_seen;
    quad(1'b0, 8);
    check("rev_steps", step_seen - s0, 8);
    check("rev_dir", dir, 0);
    check("rev_err", err_seen - e0, 0);

    // Glitches: 3-clock pulse rejected, 5-clock pulse passes.
    s0 = step_seen; t0 = af_tog;
    A = ~A; #30; A = ~A;
    wait_clocks(12);
    check("glitch30_af", af_tog - t0, 0);
    check("glitch30_steps", step_seen - s0, 0);
    A = ~A; #50; A = ~A;
    wait_clocks(14);
    check("glitch50_af", af_tog - t0, 2);
    check("glitch50_steps", step_seen - s0, 2);

    // Illegal transitions, saturation and clear.
    s0 = step_seen; e0 = err_seen;
    A = ~A; B = ~B;
    wait_clocks(8);
    check("illegal_err", err_seen - e0, 1);
    check("illegal_cnt", err_cnt, 1);
    check("illegal_step", step_seen - s0, 0);
    for (int i = 0; i < 300; i++) begin
      A = ~A; B = ~B;
      wait_clocks(8);
    end
    check("err_sat", err_cnt, 255);
    err_clr = 1'b1;
    wait_clocks(1);
    err_clr = 1'b0;
    wait_clocks(2);
    check("err_clr", err_cnt, 0);

    // Bypass: three-edge latency and a one-clock glitch passes through.
    filt_en = 1'b0;
    wait_clocks(4);
    measure_a("byp_lat", 3);
    wait_clocks(4);
    s0 = step_seen; t0 = af_tog;
    A = ~A; #10; A = ~A;
    wait_clocks(6);
    check("byp_glitch_af", af_tog - t0, 2);
    check("byp_glitch_steps", step_seen - s0, 2);

    // Mid-run reset, released with both inputs high.
    e0 = err_seen;
    B = ~B;
    #25 reset = 1'b0;
    #1;
    check("midrst_outputs", {A_f, B_f, step, dir, err, err_cnt}, 0);
    A = 1'b1; B = 1'b1;
    #20 reset = 1'b1;
    wait_clocks(10);
    check("midrst_no_err", err_seen - e0, 0);
    check("midrst_level", {A_f, B_f, err_cnt}, {2'b11, 8'd0});

    wait_clocks(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
